qdot_accum: RTL

//  Streaming fixed-point dot-product accumulator: consumes (w,x) operand pairs, accumulates sum(w*x) over one vector.

---
 rtl/qfix_pkg.sv | 21 ++
 rtl/qdot_prod.sv | 40 ++++
 rtl/qdot_accum.sv | 95 +++++++++
 3 files changed

// File: rtl/qfix_pkg.sv
// qfix_pkg: shared Q-format constants, FSM states and sign-magnitude/two's-complement helpers
package qfix_pkg;
  localparam int DEF_Q = 15;
  localparam int DEF_N = 32;
  localparam int MAXW = 64;
  typedef enum logic [2:0] {IDLE, ACC, FLUSH, SAT, OUT} state_t;
  function automatic logic [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] v, input int unsigned w);
    logic [MAXW-1:0] sb, m;
    sb = MAXW'(1) << (w - 1);
    m = v & (sb - MAXW'(1));
    return |(v & sb) ? -m : m;
  endfunction
  function automatic logic [MAXW-1:0] tc_to_sm(input logic [MAXW-1:0] v, input int unsigned w);
    logic [MAXW-1:0] sb, m;
    logic s;
    sb = MAXW'(1) << (w - 1);
    s = |(v & sb);
    m = (s ? -v : v) & (sb - MAXW'(1));
    return (s && m != '0) ? (m | sb) : m;
  endfunction
endpackage

// File: rtl/qdot_prod.sv
// qdot_prod: registered sign-magnitude Q multiply with product clamp and two's-complement output
module qdot_prod import qfix_pkg::*; #(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N,
  parameter int GUARD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [N-1:0]        w,
  input  logic [N-1:0]        x,
  output logic                valid,
  output logic [N+GUARD-1:0]  prod,
  output logic                ovf
);
  localparam int AW = N + GUARD;
  localparam int PW = 2 * (N - 1);
  logic [PW-1:0] full;
  logic [PW-Q-1:0] shifted;
  logic big;
  logic [AW-2:0] mag;
  assign full = PW'(w[N-2:0]) * PW'(x[N-2:0]);
  assign shifted = (PW-Q)'(full >> Q);
  assign big = |shifted[PW-Q-1:AW-1];
  assign mag = big ? '1 : shifted[AW-2:0];
  // register the clamped product in two's complement, with its overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      prod <= '0;
      ovf <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        prod <= AW'(sm_to_tc(MAXW'({w[N-1] ^ x[N-1], mag}), AW));
        ovf <= big;
      end
    end
  end
endmodule

// File: rtl/qdot_accum.sv
// qdot_accum: streaming saturating dot-product accumulator with optional ReLU
module qdot_accum import qfix_pkg::*; #(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_w,
  input  logic [N-1:0]     in_x,
  input  logic             in_last,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  localparam int AW = N + GUARD;
  localparam logic signed [AW-1:0] MAXA = {{(GUARD+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] MINA = -MAXA;
  localparam logic [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-2){1'b0}}, 1'b1};
  state_t state, state_nx;
  logic xfer, p_valid, p_ovf, sticky, relu, acc_ovf, hi, lo;
  logic [AW-1:0] p, acc_nx;
  logic signed [AW-1:0] acc;
  logic signed [AW:0] sum;
  logic [N-1:0] tcv;
  logic [CNT_W-1:0] cnt;
  assign xfer = in_valid & in_ready;
  qdot_prod #(.Q(Q), .N(N), .GUARD(GUARD)) u_prod (
    .clk(clk), .rst(rst), .load(xfer), .w(in_w), .x(in_x),
    .valid(p_valid), .prod(p), .ovf(p_ovf)
  );
  assign sum = {acc[AW-1], acc} + {p[AW-1], p};
  assign acc_ovf = sum[AW] ^ sum[AW-1];
  assign acc_nx = acc_ovf ? {sum[AW], {(AW-1){~sum[AW]}}} : sum[AW-1:0];
  assign hi = acc > MAXA;
  assign lo = acc < MINA;
  assign tcv = (relu & acc[AW-1]) ? '0 : hi ? MAXN : lo ? MINN : acc[N-1:0];
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  // next-state: accept beats until last, then flush, saturate and hold the result
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACC: state_nx = xfer ? (in_last ? FLUSH : ACC) : state;
      FLUSH:     state_nx = SAT;
      SAT:       state_nx = OUT;
      OUT:       state_nx = out_ready ? IDLE : OUT;
      default:   state_nx = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready = !rst && (state == IDLE || state == ACC);
    out_valid = state == OUT;
  end
  // accumulator, beat counter, sticky overflow and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sticky <= 1'b0;
      relu <= 1'b0;
      cnt <= '0;
      out_result <= '0;
      out_ovf <= 1'b0;
      out_count <= '0;
    end else begin
      if (state == OUT && out_ready) begin
        acc <= '0;
        sticky <= 1'b0;
        cnt <= '0;
      end else begin
        if (p_valid) begin
          acc <= acc_nx;
          sticky <= sticky | p_ovf | acc_ovf;
        end
        if (xfer) cnt <= &cnt ? cnt : cnt + 1'b1;
      end
      if (xfer && state == IDLE) relu <= relu_en;
      if (state == SAT) begin
        out_result <= N'(tc_to_sm(MAXW'(tcv), N));
        out_ovf <= sticky | hi | lo;
        out_count <= cnt;
      end
    end
  end
endmodule
